fifo_rd_stream: RTL

Read-side consumer stage for the sync FIFO. It drives the FIFO read enable from the controller's empty flag and absorbs the storage read latency in a 2-entry output buffer. It presents words to the downstream logic on a valid/ready stream interface. Sustains 1 word/cycle, preserves FIFO order and never loses or duplicates a word.

---
 rtl/fifo_rd_stream_pkg.sv | 12 +
 rtl/fifo_rd_stream_if.sv | 24 ++
 rtl/fifo_out_buf.sv | 43 ++++
 rtl/fifo_rd_stream.sv | 80 ++++++++
 4 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and constants for the FIFO read-side stream stage.
package fifo_pkg;

  localparam int OUT_BUF_DEPTH = 2;

  typedef logic [1:0] buf_cnt_t;

  // Legal values for RD_LATENCY.
  localparam int RD_LAT_COMB = 0;
  localparam int RD_LAT_REG  = 1;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus downstream stream; master is the fifo_rd_stream side.
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 8
);
  // Stream handshake: a word transfers on a rising edge where o_Valid and
  // i_Ready are both high; once o_Valid is raised, o_Valid and o_Data hold
  // until that transfer, and i_Ready may depend on nothing from this side.
  logic                  i_Fifo_Empty;
  logic [DATA_WIDTH-1:0] i_Fifo_Data;
  logic                  o_Rd_En;
  logic                  o_Valid;
  logic [DATA_WIDTH-1:0] o_Data;
  logic                  i_Ready;

  modport master (
    input  i_Fifo_Empty, i_Fifo_Data, i_Ready,
    output o_Rd_En, o_Valid, o_Data
  );

  modport slave (
    output i_Fifo_Empty, i_Fifo_Data, i_Ready,
    input  o_Rd_En, o_Valid, o_Data
  );
endinterface

// File: rtl/fifo_out_buf.sv
// Two-entry circular output buffer: tail write, head pop, occupancy count.
module fifo_out_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pop,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] head,
  output buf_cnt_t              count
);

  logic [DATA_WIDTH-1:0] entry [OUT_BUF_DEPTH];
  logic                  wr_ptr;
  logic                  rd_ptr;
  buf_cnt_t              cnt;

  // Entries are cleared on reset so the head reads zero until the first write.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= '0;
      for (int i = 0; i < OUT_BUF_DEPTH; i++) entry[i] <= '0;
    end else begin
      if (wr_en) begin
        entry[wr_ptr] <= wr_data;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + buf_cnt_t'(wr_en) - buf_cnt_t'(pop);
    end
  end

  assign head  = entry[rd_ptr];
  assign valid = (cnt != '0);
  assign count = cnt;

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-issue and credit logic feeding a 2-entry valid/ready output buffer.
// Optional FIFO_RD_STREAM_STATS_EN adds o_Beat_Count and o_Stall.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = RD_LAT_REG
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  fifo_rd_stream_if.master bus
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [31:0]      o_Beat_Count,
  output logic             o_Stall
`endif
);

  logic                  pop;
  logic                  wr_en;
  logic                  in_flight;
  logic                  buf_valid;
  logic [DATA_WIDTH-1:0] buf_head;
  buf_cnt_t              buf_count;
  logic [2:0]            credit;

  assign pop = buf_valid & bus.i_Ready;

  // Words already owned (stored or on their way) after this cycle's pop.
  assign credit = {1'b0, buf_count} + {2'b00, in_flight} - {2'b00, pop};
  assign bus.o_Rd_En = ~bus.i_Fifo_Empty & ~i_Reset & (credit < 3'(OUT_BUF_DEPTH));

  generate
    if (RD_LATENCY == RD_LAT_REG) begin : g_reg_read
      always_ff @(posedge i_Clk) begin
        if (i_Reset) in_flight <= 1'b0;
        else         in_flight <= bus.o_Rd_En;
      end
      assign wr_en = in_flight;
    end else begin : g_comb_read
      assign in_flight = 1'b0;
      assign wr_en     = bus.o_Rd_En;
    end
  endgenerate

  fifo_out_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk     (i_Clk),
    .reset   (i_Reset),
    .wr_en   (wr_en),
    .wr_data (bus.i_Fifo_Data),
    .pop     (pop),
    .valid   (buf_valid),
    .head    (buf_head),
    .count   (buf_count)
  );

  assign bus.o_Valid = buf_valid;
  assign bus.o_Data  = buf_head;

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0] beat_count;
  logic        stall_q;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      beat_count <= '0;
      stall_q    <= 1'b0;
    end else begin
      if (pop && (beat_count != 32'hFFFF_FFFF)) beat_count <= beat_count + 32'd1;
      stall_q <= buf_valid & ~bus.i_Ready;
    end
  end

  assign o_Beat_Count = beat_count;
  assign o_Stall      = stall_q;
`endif

endmodule
